uart_wb_host: RTL and testbench
===============================

Name: uart_wb_host

Overview:
Wishbone bus master that drives the 16550-compatible uart_top register interface, which is otherwise left unconnected inside the tile.
- After reset it programs line control, divisor and FIFO control.
- It then polls LSR continuously.
- It moves bytes from a valid/ready transmit stream into THR, and from RBR into a valid/ready receive stream.
- It sits directly upstream of uart_top on the Wishbone port; its byte streams connect to tile pins or user logic.

Parameters:
- DIVISOR, 16'd27: baud divisor written to DLL (low byte) and DLM (high byte).
- LCR_VALUE, 8'h03: line control value (8N1); bit 7 is forced 0 in the final LCR write.
- FCR_VALUE, 8'hC7: FIFO control value (enable, clear both FIFOs, trigger 14).
- ACK_TIMEOUT, 8: cycles to wait for wb_ack_i before aborting a bus cycle (at least 2).

Ports:
- clk  in  1  system clock; also the Wishbone clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wb_adr_o  out  3  register address.
- wb_dat_o  out  8  write data.
- wb_dat_i  in  8  read data.
- wb_we_o  out  1  write enable.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_sel_o  out  4  byte select; 4'b0001 while cyc is high, else 0.
- wb_ack_i  in  1  acknowledge.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-cycle pulse; the byte is accepted, i.e. written to THR.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid; held until consumed.
- rx_ready  in  1  consumer accepts rx_data.
- init_done  out  1  high once the init sequence completes.
- bus_err  out  1  sticky; set on any ack timeout.

Behaviour:
Reset values:
- All outputs 0; rx_data 0; the state machine in S_INIT with step index 0.
- Reset asserted mid-cycle drops cyc/stb immediately; init restarts after release.

Bus cycle engine:
- Asserts cyc, stb and sel together with adr/dat/we.
- Holds all of them stable until wb_ack_i is sampled high.
- Drops cyc/stb in the cycle after ack.
- At least one idle cycle separates consecutive accesses.
- Read data is captured on the ack cycle.
- If no ack arrives within ACK_TIMEOUT cycles of stb assertion, the engine deasserts cyc/stb, sets bus_err, and treats the access as complete with read data 8'h00.

Init sequence (S_INIT), five writes in order:
1. LCR (addr 3) = LCR_VALUE | 8'h80
2. DLL (addr 0) = DIVISOR[7:0]
3. DLM (addr 1) = DIVISOR[15:8]
4. LCR = LCR_VALUE & 8'h7F
5. FCR (addr 2) = FCR_VALUE

- init_done rises the cycle after the fifth ack.
- tx_ready is never asserted before init_done.

State machine (after init):
- S_POLL: read LSR (addr 5), then decide:
  - If LSR[0] (DR) = 1 and rx_valid = 0 → S_RX.
  - Else if LSR[5] (THRE) = 1 and tx_valid = 1 → S_TX.
  - Else → S_POLL again.
- S_RX: read RBR (addr 0). On ack: rx_data ← wb_dat_i, rx_valid ← 1. Return to S_POLL.
- S_TX: write THR (addr 0) = tx_data sampled at stb assertion. On ack: pulse tx_ready for one cycle. Return to S_POLL.
- RX has priority over TX when both are eligible.
- Exactly one THR write per LSR read showing THRE; no burst filling of the TX FIFO.

RX handshake:
- rx_valid clears in the cycle after rx_valid & rx_ready.
- While rx_valid = 1, DR is ignored; received data backs up in the UART FIFO. No overwrite, ever.

TX handshake:
- tx_data must stay stable while tx_valid is high and tx_ready has not pulsed.
- If tx_valid drops before the S_TX decision, no write occurs.

Decomposition:
- Package uart_wb_pkg holds:
  - Register address constants: RBR_THR = 0, IER/DLM = 1, FCR = 2, LCR = 3, LSR = 5.
  - LSR bit indices: DR = 0, THRE = 5.
  - The state enum: S_INIT, S_POLL, S_RX, S_TX.
- Sub-module uart_wb_cycle: the single-access Wishbone engine with timeout. Interface: req, we, adr, wdat in; done, rdat, timeout out.
- uart_wb_host contains the sequencing and stream handshakes.

Test Plan:
1. Reset release with a Wishbone slave model (ack one cycle after stb) → exactly five writes, in order: (3, 8'h83), (0, 8'h1B), (1, 8'h00), (3, 8'h03), (2, 8'hC7); init_done = 1 after the fifth ack.
2. tx_valid = 1, tx_data = 8'h55, LSR returns 8'h60 → one write (0, 8'h55); one tx_ready pulse; LSR polled again afterwards.
3. LSR returns 8'h00 for 10 polls with tx_valid = 1 → no THR write and tx_ready stays 0; when LSR changes to 8'h20 → write occurs on the next decision.
4. LSR returns 8'h61, RBR returns 8'hA5, tx_valid = 1 → RBR read precedes the THR write; rx_data = 8'hA5, rx_valid = 1; with rx_ready held 0, later DR = 1 does not trigger another RBR read.
5. Slave never acks during the LSR read → cyc/stb drop after 8 cycles; bus_err = 1 and stays 1; polling continues.
6. rst_n asserted while stb is high mid-TX → cyc/stb/tx_ready go 0 asynchronously; after release, init repeats from the first LCR write.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// Shared constants for the UART Wishbone host: 16550 register map,
// LSR bit positions and the sequencer state encoding.
package uart_wb_pkg;

    localparam logic [2:0] ADR_RBR_THR = 3'd0;
    localparam logic [2:0] ADR_IER_DLM = 3'd1;
    localparam logic [2:0] ADR_FCR     = 3'd2;
    localparam logic [2:0] ADR_LCR     = 3'd3;
    localparam logic [2:0] ADR_LSR     = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_THRE = 5;

    // Index of the last register write in the power-up programming sequence
    localparam logic [2:0] INIT_LAST_STEP = 3'd4;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_POLL = 2'd1,
        S_RX   = 2'd2,
        S_TX   = 2'd3
    } state_e;

endpackage

// File: rtl/uart_wb_cycle.sv
// Single-access Wishbone master engine: launches one access per request,
// holds it until ack, and abandons it after ACK_TIMEOUT strobe cycles.
module uart_wb_cycle #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [2:0] i_adr,
    input  logic [7:0] i_wdat,
    output logic       o_done,
    output logic [7:0] o_rdat,
    output logic       o_timeout,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_cyc;
    logic          r_stb;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [2:0]    r_adr;
    logic [7:0]    r_dat;
    logic          w_ack;
    logic          w_expire;

    assign w_ack    = r_stb & wb_ack_i;
    assign w_expire = r_stb & ~wb_ack_i & (r_cnt == CW'(ACK_TIMEOUT - 1));

    // Completion is reported combinationally so the sequencer acts on the ack edge itself
    always_comb begin
        o_done    = w_ack | w_expire;
        o_timeout = w_expire;
        if (w_ack) begin
            o_rdat = wb_dat_i;
        end else begin
            o_rdat = 8'h00;
        end
    end

    // Access launch, hold-until-ack and timeout abort; a new access can only start from idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_sel <= 4'b0000;
            r_adr <= 3'd0;
            r_dat <= 8'h00;
            r_cnt <= '0;
        end else if (r_stb) begin
            if (w_ack || w_expire) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
                r_sel <= 4'b0000;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (i_req) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_sel <= 4'b0001;
            r_we  <= i_we;
            r_adr <= i_adr;
            r_dat <= i_wdat;
            r_cnt <= '0;
        end else begin
            r_cnt <= '0;
        end
    end

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;

endmodule

// File: rtl/uart_wb_host.sv
// Wishbone host for a 16550-style UART: programs the line after reset, then
// polls LSR and shuttles bytes between THR/RBR and valid/ready streams.
module uart_wb_host
    import uart_wb_pkg::*;
#(
    parameter logic [15:0] DIVISOR     = 16'd27,
    parameter logic [7:0]  LCR_VALUE   = 8'h03,
    parameter logic [7:0]  FCR_VALUE   = 8'hC7,
    parameter int          ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    output logic [3:0] wb_sel_o,
    input  logic       wb_ack_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       init_done,
    output logic       bus_err
);

    state_e     r_state;
    logic [2:0] r_step;
    logic       r_init_done;
    logic       r_tx_ready;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_bus_err;

    logic       w_we;
    logic [2:0] w_adr;
    logic [7:0] w_wdat;
    logic       w_done;
    logic [7:0] w_rdat;
    logic       w_timeout;

    // Access descriptor for the current state; the engine latches it when it launches
    always_comb begin
        w_we   = 1'b0;
        w_adr  = ADR_LSR;
        w_wdat = 8'h00;
        case (r_state)
            S_INIT: begin
                w_we = 1'b1;
                case (r_step)
                    3'd0: begin w_adr = ADR_LCR;     w_wdat = LCR_VALUE | 8'h80; end
                    3'd1: begin w_adr = ADR_RBR_THR; w_wdat = DIVISOR[7:0];      end
                    3'd2: begin w_adr = ADR_IER_DLM; w_wdat = DIVISOR[15:8];     end
                    3'd3: begin w_adr = ADR_LCR;     w_wdat = LCR_VALUE & 8'h7F; end
                    default: begin w_adr = ADR_FCR;  w_wdat = FCR_VALUE;         end
                endcase
            end
            S_POLL: begin
                w_adr = ADR_LSR;
            end
            S_RX: begin
                w_adr = ADR_RBR_THR;
            end
            S_TX: begin
                w_we   = 1'b1;
                w_adr  = ADR_RBR_THR;
                w_wdat = tx_data;
            end
            default: begin
                w_adr = ADR_LSR;
            end
        endcase
    end

    uart_wb_cycle #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_cycle (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (1'b1),
        .i_we      (w_we),
        .i_adr     (w_adr),
        .i_wdat    (w_wdat),
        .o_done    (w_done),
        .o_rdat    (w_rdat),
        .o_timeout (w_timeout),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_sel_o  (wb_sel_o),
        .wb_ack_i  (wb_ack_i)
    );

    // Sequencer and stream handshakes; RX wins over TX and a held rx byte masks DR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_step      <= 3'd0;
            r_init_done <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_tx_ready <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
            if (w_done) begin
                case (r_state)
                    S_INIT: begin
                        if (r_step == INIT_LAST_STEP) begin
                            r_init_done <= 1'b1;
                            r_state     <= S_POLL;
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
                    end
                    S_POLL: begin
                        if (w_rdat[LSR_DR] && !r_rx_valid) begin
                            r_state <= S_RX;
                        end else if (w_rdat[LSR_THRE] && tx_valid) begin
                            r_state <= S_TX;
                        end else begin
                            r_state <= S_POLL;
                        end
                    end
                    S_RX: begin
                        r_rx_data  <= w_rdat;
                        r_rx_valid <= 1'b1;
                        r_state    <= S_POLL;
                    end
                    S_TX: begin
                        r_tx_ready <= 1'b1;
                        r_state    <= S_POLL;
                    end
                    default: begin
                        r_state <= S_INIT;
                        r_step  <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign init_done = r_init_done;
    assign tx_ready  = r_tx_ready;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_uart_wb_host.sv
// Bench for uart_wb_host: Wishbone slave model with programmable LSR/RBR,
// access scoreboard, decision vector table and hand sequences for timeout/reset.
module tb_uart_wb_host;
    import uart_wb_pkg::*;

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } acc_t;

    typedef struct {
        logic [7:0] lsr;
        logic [7:0] rbr;
        logic       txv;
        logic [7:0] txd;
        int         op;
    } vec_t;

    localparam int OP_NONE = 0;
    localparam int OP_RX   = 1;
    localparam int OP_TX   = 2;
    localparam int NV      = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0] wb_sel_o;
    logic       wb_ack_i;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       init_done, bus_err;

    logic [7:0] lsr_val, rbr_val;
    logic       ack_en;
    acc_t       act_q[$];
    acc_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         txr_cnt = 0;
    int         base;
    vec_t       vecs [NV];

    uart_wb_host dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .init_done(init_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (act_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("access_wait", 32'(act_q.size() >= n), 32'd1);
    endtask

    task automatic chk_acc(input string name, input acc_t e);
        acc_t a;
        if (act_q.size() == 0) begin
            chk({name, "_missing"}, 32'd0, 32'(e));
        end else begin
            a = act_q.pop_front();
            chk(name, 32'(a), 32'(e));
        end
    endtask

    task automatic run_init(input string tag);
        exp_q.push_back({1'b1, 3'd3, 8'h83});
        exp_q.push_back({1'b1, 3'd0, 8'h1B});
        exp_q.push_back({1'b1, 3'd1, 8'h00});
        exp_q.push_back({1'b1, 3'd3, 8'h03});
        exp_q.push_back({1'b1, 3'd2, 8'hC7});
        wait_acc(4, 200);
        chk({tag, "_done_early"}, 32'(init_done), 32'd0);
        wait_acc(5, 50);
        chk({tag, "_done"}, 32'(init_done), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk_acc($sformatf("%s_wr%0d", tag, i), exp_q.pop_front());
        end
    endtask

    // Wishbone slave: ack in the second strobe cycle, read data from LSR/RBR models
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_ack_i <= 1'b0;
        else        wb_ack_i <= wb_stb_o & ~wb_ack_i & ack_en;
    end

    always_comb begin
        if (wb_adr_o == ADR_LSR)          wb_dat_i = lsr_val;
        else if (wb_adr_o == ADR_RBR_THR) wb_dat_i = rbr_val;
        else                              wb_dat_i = 8'h00;
    end

    // Monitor: log completed accesses, count tx_ready pulses, check bus invariants
    logic       prev_stb = 1'b0;
    logic [11:0] prev_bus = 12'h000;
    always @(posedge clk) begin
        if (rst_n) begin
            if (wb_stb_o && wb_ack_i) begin
                act_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
                chk("sel_cyc_on_ack", 32'({wb_cyc_o, wb_sel_o}), 32'h11);
            end
            if (wb_stb_o && prev_stb)
                chk("hold_stable", 32'({wb_we_o, wb_adr_o, wb_dat_o}), 32'(prev_bus));
            if (tx_ready) begin
                txr_cnt++;
                chk("tx_ready_after_init", 32'(init_done), 32'd1);
            end
        end
        prev_stb = wb_stb_o;
        prev_bus = {wb_we_o, wb_adr_o, wb_dat_o};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        acc_t e;
        vecs[0] = '{8'h60, 8'h00, 1'b1, 8'h55, OP_TX};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 8'h12, OP_NONE};
        vecs[2] = '{8'h20, 8'h00, 1'b1, 8'h3C, OP_TX};
        vecs[3] = '{8'h61, 8'hA5, 1'b1, 8'h44, OP_RX};
        vecs[4] = '{8'h01, 8'h5A, 1'b0, 8'h00, OP_RX};
        vecs[5] = '{8'h20, 8'h00, 1'b0, 8'h66, OP_NONE};
        vecs[6] = '{8'h21, 8'h77, 1'b1, 8'h99, OP_RX};
        vecs[7] = '{8'hDE, 8'h00, 1'b1, 8'h88, OP_NONE};
        vecs[8] = '{8'hFF, 8'hC3, 1'b1, 8'h11, OP_RX};

        lsr_val = 8'h00; rbr_val = 8'h00; ack_en = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}), 32'd0);
        chk("reset_streams", 32'({tx_ready, rx_valid, rx_data, init_done, bus_err}), 32'd0);

        // Init sequence after reset release
        act_q.delete();
        rst_n = 1'b1;
        run_init("init");

        // No THR write while THRE is clear, then exactly one when it sets
        tx_valid = 1'b1; tx_data = 8'h3C; lsr_val = 8'h00;
        base = txr_cnt;
        act_q.delete();
        wait_acc(10, 300);
        for (int i = 0; i < 10; i++) chk_acc($sformatf("busy_poll%0d", i), {1'b0, ADR_LSR, 8'h00});
        chk("busy_no_tx_ready", 32'(txr_cnt - base), 32'd0);
        lsr_val = 8'h20;
        act_q.delete();
        wait_acc(2, 100);
        chk_acc("thre_lsr", {1'b0, ADR_LSR, 8'h20});
        chk_acc("thre_write", {1'b1, ADR_RBR_THR, 8'h3C});
        tx_valid = 1'b0; lsr_val = 8'h00;
        @(negedge clk);
        chk("thre_tx_ready", 32'(txr_cnt - base), 32'd1);

        // Decision table: one LSR read followed by the expected next access
        for (int i = 0; i < NV; i++) begin
            lsr_val = vecs[i].lsr; rbr_val = vecs[i].rbr;
            tx_valid = vecs[i].txv; tx_data = vecs[i].txd;
            base = txr_cnt;
            act_q.delete();
            wait_acc(2, 100);
            chk_acc($sformatf("v%0d_lsr", i), {1'b0, ADR_LSR, vecs[i].lsr});
            case (vecs[i].op)
                OP_RX:   e = {1'b0, ADR_RBR_THR, vecs[i].rbr};
                OP_TX:   e = {1'b1, ADR_RBR_THR, vecs[i].txd};
                default: e = {1'b0, ADR_LSR, vecs[i].lsr};
            endcase
            chk_acc($sformatf("v%0d_next", i), e);
            tx_valid = 1'b0; lsr_val = 8'h00;
            @(negedge clk);
            chk($sformatf("v%0d_tx_ready", i), 32'(txr_cnt - base), (vecs[i].op == OP_TX) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_rx_valid", i), 32'(rx_valid), (vecs[i].op == OP_RX) ? 32'd1 : 32'd0);
            if (vecs[i].op == OP_RX) chk($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].rbr));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            chk($sformatf("v%0d_rx_clear", i), 32'(rx_valid), 32'd0);
        end

        // RX before TX, then a held rx byte masks DR
        rbr_val = 8'hA5; lsr_val = 8'h61; tx_valid = 1'b1; tx_data = 8'hE7;
        act_q.delete();
        wait_acc(4, 200);
        tx_valid = 1'b0;
        chk_acc("prio_lsr0", {1'b0, ADR_LSR, 8'h61});
        chk_acc("prio_rbr", {1'b0, ADR_RBR_THR, 8'hA5});
        chk_acc("prio_lsr1", {1'b0, ADR_LSR, 8'h61});
        chk_acc("prio_thr", {1'b1, ADR_RBR_THR, 8'hE7});
        chk("prio_rx", 32'({rx_valid, rx_data}), 32'h1A5);
        act_q.delete();
        wait_acc(4, 200);
        for (int i = 0; i < 4; i++) chk_acc($sformatf("hold_poll%0d", i), {1'b0, ADR_LSR, 8'h61});
        chk("hold_rx", 32'({rx_valid, rx_data}), 32'h1A5);
        rx_ready = 1'b1; lsr_val = 8'h00;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("hold_rx_clear", 32'(rx_valid), 32'd0);

        // Ack timeout during LSR polling
        chk("pre_bus_err", 32'(bus_err), 32'd0);
        ack_en = 1'b0;
        k = 0;
        while (wb_stb_o && k < 100) begin @(negedge clk); k++; end
        while (!wb_stb_o && k < 100) begin @(negedge clk); k++; end
        chk("to_read_lsr", 32'({wb_we_o, wb_adr_o}), 32'(ADR_LSR));
        n = 0;
        while (wb_stb_o && n < 50) begin n++; @(negedge clk); end
        chk("to_stb_cycles", 32'(n), 32'd8);
        chk("to_bus_err", 32'({bus_err, wb_cyc_o, wb_stb_o}), 32'b100);
        ack_en = 1'b1;
        act_q.delete();
        wait_acc(2, 100);
        chk_acc("to_poll0", {1'b0, ADR_LSR, 8'h00});
        chk_acc("to_poll1", {1'b0, ADR_LSR, 8'h00});
        chk("to_bus_err_sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a THR write
        lsr_val = 8'h20; tx_valid = 1'b1; tx_data = 8'hAA;
        base = txr_cnt;
        k = 0;
        while (!(wb_stb_o && wb_we_o) && k < 200) begin @(negedge clk); k++; end
        chk("rst_found_write", 32'({wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}), 32'({2'b11, ADR_RBR_THR, 8'hAA}));
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({wb_cyc_o, wb_stb_o, tx_ready, bus_err, init_done}), 32'd0);
        repeat (2) @(negedge clk);
        tx_valid = 1'b0; lsr_val = 8'h00;
        act_q.delete();
        rst_n = 1'b1;
        run_init("reinit");
        chk("rst_no_tx_ready", 32'(txr_cnt - base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
